// File: rtl/addsub_pkg.sv
// Shared types for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Control payload that travels alongside each pipeline stage.
    typedef struct packed {
        logic valid;
        logic sign_a;  // sign of operand a
        logic sign_b;  // sign of effective operand b' (inverted for subtract)
    } stage_ctl_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
interface pipe_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;

    // Producer/consumer side.
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
    );

    // Adder side.
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
    );
endinterface

// File: rtl/addsub_stage.sv
// One CHUNK-bit registered adder slice with carry in/out and a hold enable.
module addsub_stage #(
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);
    logic [CHUNK:0] w_total;
    logic [CHUNK:0] r_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + (CHUNK + 1)'(i_cin);

    // Capture the slice sum and carry when the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (i_en) begin
            r_total <= w_total;
        end
    end

    assign o_sum  = r_total[CHUNK-1:0];
    assign o_cout = r_total[CHUNK];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage, global stall.
// Optional macro PIPE_ADDSUB_SAT_EN: saturate out_sum on signed overflow.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input logic          clk,
    input logic          rst_n,
    pipe_addsub_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    if ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of CHUNK and CHUNK <= WIDTH");
    end

    op_e              w_op;
    logic             w_adv;
    // Index k is the input side of stage k; index STAGES is the pipeline output.
    logic [WIDTH-1:0] w_x   [STAGES];
    logic [WIDTH-1:0] w_y   [STAGES];
    logic [WIDTH-1:0] w_r   [STAGES+1];
    logic             w_c   [STAGES+1];
    stage_ctl_t       w_ctl [STAGES+1];

    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    stage_ctl_t       w_out_ctl;

    assign w_op  = op_e'(bus.in_sub);
    // A single advance signal: every stage moves or every stage holds.
    assign w_adv = !w_ctl[STAGES].valid || bus.out_ready;

    assign w_x[0]   = bus.in_a;
    assign w_y[0]   = (w_op == OP_SUB) ? ~bus.in_b : bus.in_b;
    assign w_c[0]   = (w_op == OP_SUB);
    assign w_r[0]   = '0;
    assign w_ctl[0] = '{valid: bus.in_valid, sign_a: bus.in_a[WIDTH-1],
                        sign_b: w_y[0][WIDTH-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_s;
        logic             w_co;
        logic [WIDTH-1:0] r_res;
        stage_ctl_t       r_ctl;

        addsub_stage #(
            .CHUNK (CHUNK)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_a    (w_x[k][CHUNK-1:0]),
            .i_b    (w_y[k][CHUNK-1:0]),
            .i_cin  (w_c[k]),
            .o_sum  (w_s),
            .o_cout (w_co)
        );

        // Carry already-computed low result bits and the control payload forward.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_res <= '0;
                r_ctl <= '0;
            end else if (w_adv) begin
                r_res <= w_r[k];
                r_ctl <= w_ctl[k];
            end
        end

        assign w_r[k+1]   = r_res | (WIDTH'(w_s) << (k * CHUNK));
        assign w_c[k+1]   = w_co;
        assign w_ctl[k+1] = r_ctl;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] r_x;
            logic [WIDTH-1:0] r_y;

            // Shift the unprocessed operand bits down so the next slice sees them at bit 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (w_adv) begin
                    r_x <= w_x[k] >> CHUNK;
                    r_y <= w_y[k] >> CHUNK;
                end
            end

            assign w_x[k+1] = r_x;
            assign w_y[k+1] = r_y;
        end
    end

    if (STAGES > 1) begin : g_sink
        // The last slice only consumes the low chunk of its operand inputs.
        logic w_unused_hi;
        assign w_unused_hi = ^{w_x[STAGES-1][WIDTH-1:CHUNK], w_y[STAGES-1][WIDTH-1:CHUNK]};
    end

    assign w_out_ctl = w_ctl[STAGES];
    assign w_raw     = w_r[STAGES];
    assign w_ovf     = signed_ovf(w_out_ctl.sign_a, w_out_ctl.sign_b, w_raw[WIDTH-1]);

`ifdef PIPE_ADDSUB_SAT_EN
    // Clamp toward the operands' common sign on overflow.
    always_comb begin
        w_sum = w_raw;
        if (w_ovf) begin
            w_sum = w_out_ctl.sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_sum = w_raw;
`endif

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = w_out_ctl.valid;
    assign bus.out_sum   = w_sum;
    assign bus.out_carry = w_c[STAGES];
    assign bus.out_ovf   = w_ovf;
    // Gated by valid so the flag reads 0 out of reset.
    assign bus.out_zero  = w_out_ctl.valid && (w_sum == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (WIDTH=8, CHUNK=4).
module tb_pipe_addsub;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 4;
`ifdef PIPE_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipe_addsub #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Back-to-back vectors with hand-computed results.
    logic [7:0] bb_a   [4] = '{8'h12, 8'h0F, 8'h05, 8'h80};
    logic [7:0] bb_b   [4] = '{8'h34, 8'h01, 8'h07, 8'h80};
    logic       bb_sub [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] bb_sum [4] = '{8'h46, 8'h10, 8'hFE, SAT ? 8'h80 : 8'h00};
    logic       bb_c   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = s;
    endtask

    // Single operation with out_ready high: latency, result, flags, trailing bubble.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] esum, input logic ec,
                          input logic eovf, input logic ez);
        @(negedge clk);
        drive(1'b1, a, b, sub);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check({tag, "/early_valid"}, 8'(bus.out_valid), 8'h00);
        @(negedge clk);
        check({tag, "/valid"}, 8'(bus.out_valid), 8'h01);
        check({tag, "/sum"},   bus.out_sum, esum);
        check({tag, "/carry"}, 8'(bus.out_carry), 8'(ec));
        check({tag, "/ovf"},   8'(bus.out_ovf), 8'(eovf));
        check({tag, "/zero"},  8'(bus.out_zero), 8'(ez));
        @(negedge clk);
        check({tag, "/bubble"}, 8'(bus.out_valid), 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int oidx;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst/out_valid", 8'(bus.out_valid), 8'h00);
        check("rst/in_ready",  8'(bus.in_ready), 8'h01);
        check("rst/out_sum",   bus.out_sum, 8'h00);
        check("rst/out_carry", 8'(bus.out_carry), 8'h00);
        check("rst/out_ovf",   8'(bus.out_ovf), 8'h00);
        check("rst/out_zero",  8'(bus.out_zero), 8'h00);
        rst_n = 1'b1;

        run_op("ff_add_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("7f_add_01", 8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("80_sub_01", 8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("05_sub_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("07_sub_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op("80_add_80", 8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1, !SAT);
        run_op("0f_add_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);

        // Four ops back-to-back; consumer stalls for five cycles once results appear.
        idx  = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 40 && oidx < 4; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 2 && cyc <= 6);
            if (idx < 4) drive(1'b1, bb_a[idx], bb_b[idx], bb_sub[idx]);
            else         drive(1'b0, 8'h00, 8'h00, 1'b0);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                check("bb/stall_in_ready", 8'(bus.in_ready), 8'h00);
                check("bb/stall_hold_sum", bus.out_sum, bb_sum[oidx]);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("bb/sum%0d", oidx),   bus.out_sum, bb_sum[oidx]);
                check($sformatf("bb/carry%0d", oidx), 8'(bus.out_carry), 8'(bb_c[oidx]));
                oidx++;
            end
        end
        check("bb/results_delivered", 8'(oidx), 8'd4);
        check("bb/ops_accepted",      8'(idx), 8'd4);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bb/no_duplicate", 8'(bus.out_valid), 8'h00);
        end

        // Reset with two operations in flight.
        @(negedge clk);
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h33, 8'h44, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        check("mid_rst/in_flight", 8'(bus.out_valid), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst/valid_drop", 8'(bus.out_valid), 8'h00);
        check("mid_rst/in_ready",   8'(bus.in_ready), 8'h01);
        check("mid_rst/sum_clear",  bus.out_sum, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst/no_output", 8'(bus.out_valid), 8'h00);
        end
        run_op("post_rst_21_sub_13", 8'h21, 8'h13, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, meaning bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands, two's complement or unsigned.
REQ-008 in_sub  input  1  0 = a+b, 1 = a-b.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_sum  output  WIDTH  result.
REQ-012 out_carry  output  1  unsigned carry-out; for subtract, 1 = no borrow (a >= b unsigned).
REQ-013 out_ovf  output  1  signed overflow of the unsaturated result.
REQ-014 out_zero  output  1  out_sum equals zero.

Function
REQ-015 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-016 Subtract implemented as a + ~b with stage-0 carry-in 1; add uses carry-in 0.
REQ-017 Stage k adds bits [k*CHUNK +: CHUNK] with carry registered from stage k-1; higher operand bits and lower result bits are carried forward in pipeline registers.
REQ-018 Latency exactly STAGES cycles from input transfer to out_valid with no stall (default: 2).
REQ-019 Throughput one operation per cycle when out_ready stays high; results leave in issue order.
REQ-020 Global stall: in_ready = !out_valid || out_ready; when stalled, every stage register holds.
REQ-021 out_sum, flags and out_valid stay stable while out_valid && !out_ready.
REQ-022 Bubbles propagate as invalid stage entries; no spurious out_valid.
REQ-023 out_ovf = (sign a' == sign b') && (sign sum != sign a'), where b' is the effective (inverted for subtract) operand.
REQ-024 out_zero computed from the final out_sum, after saturation when enabled.
REQ-025 WIDTH not a multiple of CHUNK, or CHUNK > WIDTH, produces an elaboration error.

Reset
REQ-026 rst_n low clears all stage valid bits immediately; out_valid = 0, in_ready = 1 while in reset.
REQ-027 out_sum, out_carry, out_ovf, out_zero reset to 0.
REQ-028 Reset during operation discards all in-flight operations; none emerge after release.

Configuration
REQ-029 Macro PIPE_ADDSUB_SAT_EN defined: when out_ovf = 1, out_sum clamps to signed max (0x7F..F) on positive overflow or signed min (0x80..0) on negative overflow; out_carry unaffected.
REQ-030 Macro undefined: out_sum is the wrapped modulo-2^WIDTH result; no saturation logic present.

Structure
REQ-031 Package addsub_pkg holds the op enum (OP_ADD, OP_SUB) and the stage-payload struct typedef.
REQ-032 One sub-module, addsub_stage: a CHUNK-bit registered adder slice with carry in/out and hold enable, instantiated STAGES times.

Verification (WIDTH=8, CHUNK=4)
REQ-033 add 0xFF+0x01 -> after 2 cycles out_sum 0x00, carry 1, ovf 0, zero 1.
REQ-034 add 0x7F+0x01 -> out_sum 0x80, ovf 1 (0x7F with PIPE_ADDSUB_SAT_EN); sub 0x80-0x01 -> 0x7F, ovf 1 (0x80 saturated).
REQ-035 sub 0x05-0x07 -> out_sum 0xFE, carry 0, ovf 0; sub 0x07-0x05 -> 0x02, carry 1.
REQ-036 Issue 4 ops back-to-back, out_ready low 5 cycles from first out_valid -> in_ready low while stalled, all 4 results delivered in order, none duplicated or lost.
REQ-037 Two ops in flight, pulse rst_n low mid-cycle -> out_valid drops asynchronously, no output after release until new input accepted.
